// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction fetcher for the Tomasulo core. It owns the PC and fills a small
//   instruction queue, either from a direct-mapped i-cache with one word per line
//   or through a MemoryController read. JAL targets are predicted at fetch time.
//   The ROB, RS and LSB full flags throttle issue to the Decoder. An ROB rollback
//   flushes the queue and restarts the PC.
//
//   Build option: define ICACHE_EN to include the i-cache. Without it, hit is
//   tied to 0, so every fetch goes through the MemoryController, and DRAIN only
//   discards the late word. The port list is the same in both builds.
//
//   Ports
//     clk, rst                 clock; asynchronous active-high reset
//     mc_ready_in              read data valid (one-cycle pulse)
//     mc_instruction_in [31:0] fetched word, valid with mc_ready_in
//     mc_request_out           read request pulse
//     mc_address_out [31:0]    fetch address, held until the next request
//     rs_full_in, lsb_full_in, rob_full_in   issue throttles
//     rob_rollback_in          flush; has priority over fetch and issue
//     rob_rollback_pc_in[31:0] restart PC
//     dec_issue_out            issue pulse to the Decoder
//     dec_inst_out, dec_pc_out, dec_predict_pc_out [31:0]  issued entry
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | fetch from cache on hit, or send a read on miss when queue not full
//   WAITING  | read outstanding; the returned word is pushed into the queue
//   DRAIN    | read outstanding but made stale by a rollback; fill only, no push
module fetch_queue_unit #(
    parameter int          IQ_DEPTH_LOG      = 2,
    parameter int          ICACHE_INDEX_BITS = 6,
    parameter logic [31:0] RESET_PC          = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mc_ready_in,
    input  logic [31:0] mc_instruction_in,
    output logic        mc_request_out,
    output logic [31:0] mc_address_out,
    input  logic        rs_full_in,
    input  logic        lsb_full_in,
    input  logic        rob_full_in,
    input  logic        rob_rollback_in,
    input  logic [31:0] rob_rollback_pc_in,
    output logic        dec_issue_out,
    output logic [31:0] dec_inst_out,
    output logic [31:0] dec_pc_out,
    output logic [31:0] dec_predict_pc_out
);

    localparam int IQ_DEPTH = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG:0] IQ_FULL = (IQ_DEPTH_LOG + 1)'(IQ_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAITING = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] pc;
    logic [IQ_DEPTH_LOG-1:0] head, tail;
    logic [IQ_DEPTH_LOG:0]   count;
    logic [31:0] q_inst [IQ_DEPTH];
    logic [31:0] q_pc   [IQ_DEPTH];
    logic [31:0] q_npc  [IQ_DEPTH];

    logic        q_full;
    logic        hit;
    logic [31:0] hit_inst;
    logic        push, pop, req, fill;
    logic [31:0] fetch_inst;
    logic [31:0] jal_imm;
    logic [31:0] npc;

    assign q_full = (count == IQ_FULL);

`ifdef ICACHE_EN
    localparam int TAG_W = 30 - ICACHE_INDEX_BITS;
    localparam int LINES = 1 << ICACHE_INDEX_BITS;

    logic [LINES-1:0] c_valid;
    logic [TAG_W-1:0] c_tag  [LINES];
    logic [31:0]      c_data [LINES];

    logic [ICACHE_INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]             rd_tag, wr_tag;

    assign rd_idx   = pc[ICACHE_INDEX_BITS+1:2];
    assign rd_tag   = pc[31:ICACHE_INDEX_BITS+2];
    // Fills always use the latched request address. After a rollback, pc no
    // longer points at the line that is being returned.
    assign wr_idx   = mc_address_out[ICACHE_INDEX_BITS+1:2];
    assign wr_tag   = mc_address_out[31:ICACHE_INDEX_BITS+2];
    assign hit      = c_valid[rd_idx] && (c_tag[rd_idx] == rd_tag);
    assign hit_inst = c_data[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid <= '0;
        end else if (fill) begin
            c_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            c_tag[wr_idx]  <= wr_tag;
            c_data[wr_idx] <= mc_instruction_in;
        end
    end
`else
    logic        unused_fill;
    logic [31:0] unused_cfg;

    assign hit         = 1'b0;
    assign hit_inst    = '0;
    assign unused_fill = fill;
    assign unused_cfg  = 32'(ICACHE_INDEX_BITS);
`endif

    // J-type immediate: inst[31] is sign, then [19:12], [20], [30:21], and an implicit 0.
    assign jal_imm = {{12{fetch_inst[31]}}, fetch_inst[19:12], fetch_inst[20],
                      fetch_inst[30:21], 1'b0};
    assign npc     = (fetch_inst[6:0] == 7'b1101111) ? pc + jal_imm : pc + 32'd4;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. If a rollback in WAITING coincides with the returning word,
    // the read is already finished, so go to IDLE instead of DRAIN. Otherwise
    // DRAIN would wait for a reply that never comes.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rob_rollback_in && !q_full && !hit) begin
                    state_nxt = S_WAITING;
                end
            end
            S_WAITING: begin
                if (mc_ready_in) begin
                    state_nxt = S_IDLE;
                end else if (rob_rollback_in) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mc_ready_in) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        push       = 1'b0;
        req        = 1'b0;
        fill       = 1'b0;
        fetch_inst = '0;
        case (state)
            S_IDLE: begin
                if (!rob_rollback_in && !q_full) begin
                    if (hit) begin
                        push       = 1'b1;
                        fetch_inst = hit_inst;
                    end else begin
                        req = 1'b1;
                    end
                end
            end
            S_WAITING: begin
                if (mc_ready_in) begin
                    fill = 1'b1;
                    if (!rob_rollback_in) begin
                        push       = 1'b1;
                        fetch_inst = mc_instruction_in;
                    end
                end
            end
            S_DRAIN: begin
                fill = mc_ready_in;
            end
            default: ;
        endcase
    end

    assign pop = (count != '0) && !rs_full_in && !lsb_full_in && !rob_full_in
                 && !rob_rollback_in;

    // PC, queue pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                 <= RESET_PC;
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            mc_request_out     <= 1'b0;
            mc_address_out     <= '0;
            dec_issue_out      <= 1'b0;
            dec_inst_out       <= '0;
            dec_pc_out         <= '0;
            dec_predict_pc_out <= '0;
        end else begin
            mc_request_out <= req;
            dec_issue_out  <= pop;
            if (req) begin
                mc_address_out <= pc;
            end
            if (rob_rollback_in) begin
                pc    <= rob_rollback_pc_in;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                    pc   <= npc;
                end
                if (pop) begin
                    dec_inst_out       <= q_inst[head];
                    dec_pc_out         <= q_pc[head];
                    dec_predict_pc_out <= q_npc[head];
                    head               <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail] <= fetch_inst;
            q_pc[tail]   <= pc;
            q_npc[tail]  <= npc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mc_ready_in;
    logic [31:0] mc_instruction_in;
    logic        mc_request_out;
    logic [31:0] mc_address_out;
    logic        rs_full_in, lsb_full_in, rob_full_in;
    logic        rob_rollback_in;
    logic [31:0] rob_rollback_pc_in;
    logic        dec_issue_out;
    logic [31:0] dec_inst_out, dec_pc_out, dec_predict_pc_out;

    fetch_queue_unit dut (
        .clk                (clk),
        .rst                (rst),
        .mc_ready_in        (mc_ready_in),
        .mc_instruction_in  (mc_instruction_in),
        .mc_request_out     (mc_request_out),
        .mc_address_out     (mc_address_out),
        .rs_full_in         (rs_full_in),
        .lsb_full_in        (lsb_full_in),
        .rob_full_in        (rob_full_in),
        .rob_rollback_in    (rob_rollback_in),
        .rob_rollback_pc_in (rob_rollback_pc_in),
        .dec_issue_out      (dec_issue_out),
        .dec_inst_out       (dec_inst_out),
        .dec_pc_out         (dec_pc_out),
        .dec_predict_pc_out (dec_predict_pc_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] req_q[$];
    logic [31:0] iss_pc[$];
    logic [31:0] iss_pred[$];
    logic [31:0] iss_inst[$];
    int          iss_cyc[$];

    int          mc_cnt = 0;
    logic [31:0] mc_addr = '0;

    // Program: 0x10 holds JAL +0x10 (to 0x20); 0x30 holds JAL -0x20 (back to 0x10).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h0100006F;
            32'h30:  return 32'hFE1FF06F;
            default: return 32'h00000013;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, log events, then step the MC model.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (dec_issue_out) begin
            iss_pc.push_back(dec_pc_out);
            iss_pred.push_back(dec_predict_pc_out);
            iss_inst.push_back(dec_inst_out);
            iss_cyc.push_back(cyc);
        end
        mc_ready_in = 1'b0;
        if (mc_cnt > 0) begin
            mc_cnt--;
            if (mc_cnt == 0) begin
                mc_ready_in       = 1'b1;
                mc_instruction_in = mem_word(mc_addr);
            end
        end
        if (mc_request_out) begin
            mc_cnt  = 2;
            mc_addr = mc_address_out;
            req_q.push_back(mc_address_out);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        req_q.delete();
        iss_pc.delete();
        iss_pred.delete();
        iss_inst.delete();
        iss_cyc.delete();
    endtask

    task automatic wait_iss(input int n, input int budget, input string tag);
        int b = 0;
        while (iss_pc.size() < n && b < budget) begin
            step();
            b++;
        end
        if (iss_pc.size() < n) check_val(tag, 32'(iss_pc.size()), 32'(n));
    endtask

    task automatic wait_req(input int n, input int budget, input string tag);
        int b = 0;
        while (req_q.size() < n && b < budget) begin
            step();
            b++;
        end
        if (req_q.size() < n) check_val(tag, 32'(req_q.size()), 32'(n));
    endtask

    task automatic rollback(input logic [31:0] p);
        rob_rollback_in    = 1'b1;
        rob_rollback_pc_in = p;
        step();
        rob_rollback_in    = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        mc_ready_in        = 1'b0;
        mc_instruction_in  = '0;
        rs_full_in         = 1'b0;
        lsb_full_in        = 1'b0;
        rob_full_in        = 1'b0;
        rob_rollback_in    = 1'b0;
        rob_rollback_pc_in = '0;

        // Reset values
        run(3);
        check_val("rst_req",   32'(mc_request_out), 32'd0);
        check_val("rst_addr",  mc_address_out,      32'h0);
        check_val("rst_issue", 32'(dec_issue_out),  32'd0);
        check_val("rst_pc",    dec_pc_out,          32'h0);
        rst = 1'b0;

        // Cold start: 0,4,8 via MC; JAL at 0x10 redirects to 0x20
        wait_iss(6, 200, "cold_timeout");
        check_val("cold_req0",  req_q[0],    32'h0);
        check_val("cold_req1",  req_q[1],    32'h4);
        check_val("cold_req2",  req_q[2],    32'h8);
        check_val("jal_req",    req_q[5],    32'h20);
        check_val("cold_pc0",   iss_pc[0],   32'h0);
        check_val("cold_pc1",   iss_pc[1],   32'h4);
        check_val("cold_pc2",   iss_pc[2],   32'h8);
        check_val("cold_pr0",   iss_pred[0], 32'h4);
        check_val("cold_pr1",   iss_pred[1], 32'h8);
        check_val("cold_pr2",   iss_pred[2], 32'hC);
        check_val("cold_inst0", iss_inst[0], 32'h00000013);
        check_val("jal_pc",     iss_pc[4],   32'h10);
        check_val("jal_inst",   iss_inst[4], 32'h0100006F);
        check_val("jal_pred",   iss_pred[4], 32'h20);
        check_val("jal_tgt_pc", iss_pc[5],   32'h20);

        // Loop re-fetch from 0
        rob_full_in = 1'b1;
        run(40);
        clear_logs();
        rob_full_in = 1'b0;
        rollback(32'h0);
        wait_iss(3, 60, "refetch_timeout");
        check_val("refetch_pc0", iss_pc[0], 32'h0);
        check_val("refetch_pc1", iss_pc[1], 32'h4);
        check_val("refetch_pc2", iss_pc[2], 32'h8);
`ifdef ICACHE_EN
        check_val("refetch_nreq", 32'(req_q.size()),         32'd0);
        check_val("refetch_b2b",  32'(iss_cyc[2] - iss_cyc[0]), 32'd2);
`else
        check_val("refetch_req0", req_q[0], 32'h0);
`endif

        // Queue saturation under rob_full, then release
        rob_full_in = 1'b1;
        run(40);
        rollback(32'h0);
        run(40);
        clear_logs();
        run(10);
        check_val("sat_nreq",   32'(req_q.size()),  32'd0);
        check_val("sat_nissue", 32'(iss_pc.size()), 32'd0);
        rob_full_in = 1'b0;
        wait_iss(11, 300, "release_timeout");
        check_val("rel_pc0",  iss_pc[0], 32'h0);
        check_val("rel_pc3",  iss_pc[3], 32'hC);
        check_val("rel_b2b",  32'(iss_cyc[3] - iss_cyc[0]), 32'd3);
        check_val("rel_pc4",  iss_pc[4], 32'h10);
        check_val("bjal_pc",  iss_pc[9],   32'h30);
        check_val("bjal_pr",  iss_pred[9], 32'h10);
        check_val("bjal_nxt", iss_pc[10],  32'h10);
`ifndef ICACHE_EN
        check_val("rel_req0", req_q[0], 32'h10);
`endif

        // Rollback during WAITING for 0x40
        rob_full_in = 1'b1;
        run(40);
        clear_logs();
        rollback(32'h40);
        wait_req(1, 20, "w40_timeout");
        check_val("w40_req", req_q[0], 32'h40);
        rob_full_in = 1'b0;
        rollback(32'h100);
        wait_iss(1, 60, "rb100_timeout");
        check_val("rb100_pc",  iss_pc[0], 32'h100);
        check_val("rb100_req", req_q[1],  32'h100);
        rob_full_in = 1'b1;
        run(40);
        clear_logs();
        rollback(32'h40);
        wait_req(1, 30, "line40_timeout");
`ifdef ICACHE_EN
        check_val("line40_req", req_q[0], 32'h44);
`else
        check_val("line40_req", req_q[0], 32'h40);
`endif

        // Async reset between clock edges while WAITING
        clear_logs();
        rollback(32'h200);
        wait_req(1, 30, "w200_timeout");
        check_val("w200_req", req_q[0], 32'h200);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_req",   32'(mc_request_out), 32'd0);
        check_val("arst_addr",  mc_address_out,      32'h0);
        check_val("arst_issue", 32'(dec_issue_out),  32'd0);
        check_val("arst_inst",  dec_inst_out,        32'h0);
        check_val("arst_pc",    dec_pc_out,          32'h0);
        check_val("arst_pred",  dec_predict_pc_out,  32'h0);
        mc_cnt      = 0;
        mc_ready_in = 1'b0;
        run(3);
        rst = 1'b0;
        clear_logs();
        wait_req(1, 20, "post_rst_timeout");
        check_val("post_rst_req", req_q[0], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
